bkm_d_select_seq: RTL and testbench

- Iterative digit-selection controller for the BKM complex datapath. It sits directly upstream of the CSD complex multiply-by-d stage.
- Holds the CSD complex residual (x + j·y) in registers and, once per iteration, picks the digit pair d_x, d_y ∈ {-1, 0, +1} from a 3-digit window of the residual.
- Presents the digit pair to the multiply stage, then waits for the updated residual from the downstream update path before the next iteration.

---
 rtl/bkm_pkg.sv | 30 +++
 rtl/csd_window_select.sv | 43 ++++
 rtl/bkm_d_select_seq.sv | 127 ++++++++++++
 tb/tb_bkm_d_select_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bkm_pkg.sv
// Shared definitions for the BKM digit-selection slice: CSD digit codes,
// the selection FSM state encoding, selection thresholds and a helper that
// turns a 2-bit CSD digit code into its signed value.
package bkm_pkg;

    localparam logic [1:0] CSD_ZERO = 2'b00;
    localparam logic [1:0] CSD_POS  = 2'b01;
    localparam logic [1:0] CSD_NEG  = 2'b11;

    // Window sums at or beyond these magnitudes select a non-zero digit
    localparam int SEL_HI = 2;
    localparam int SEL_LO = -2;

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        WAIT_RES,
        DONE
    } state_t;

    // 10 is a redundant zero encoding, so only 01 and 11 carry weight
    function automatic int csd_digit_value(input logic [1:0] code);
        case (code)
            CSD_POS: return 1;
            CSD_NEG: return -1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/csd_window_select.sv
// Combinational digit selector: looks at the three most significant digits
// still in play for iteration n (positions W-1-n, W-2-n, W-3-n with weights
// 4, 2, 1) and rounds the window sum to a digit in {-1, 0, +1}.
module csd_window_select
    import bkm_pkg::*;
#(
    parameter int W  = 64,
    parameter int IW = 6
) (
    input  logic [2*W-1:0] residual,
    input  logic [IW-1:0]  iter,
    output logic [1:0]     digit
);

    // Positions that fall below digit 0 contribute nothing to the window
    function automatic int digit_at(input logic [2*W-1:0] vec, input int pos);
        logic [2*W-1:0] shifted;
        if (pos < 0) begin
            return 0;
        end
        shifted = vec >> (2 * pos);
        return csd_digit_value(shifted[1:0]);
    endfunction

    int top_pos;
    int window_sum;

    // Weighted window sum followed by threshold rounding to a CSD digit
    always_comb begin
        top_pos    = W - 1 - int'(iter);
        window_sum = 4 * digit_at(residual, top_pos)
                   + 2 * digit_at(residual, top_pos - 1)
                   +     digit_at(residual, top_pos - 2);
        if (window_sum >= SEL_HI) begin
            digit = CSD_POS;
        end else if (window_sum <= SEL_LO) begin
            digit = CSD_NEG;
        end else begin
            digit = CSD_ZERO;
        end
    end

endmodule

// File: rtl/bkm_d_select_seq.sv
// Iterative digit-selection controller for the BKM complex datapath.
// Holds the CSD residual, selects one (d_x, d_y) pair per iteration, hands it
// to the multiply-by-d stage and waits for the updated residual to return.
// Optional non-zero digit-pair counter enabled by defining BKM_DSEL_NZ_COUNT_EN.
module bkm_d_select_seq
    import bkm_pkg::*;
#(
    parameter int W  = 64,
    parameter int N  = 64,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] x_in,
    input  logic [2*W-1:0] y_in,
    input  logic           res_valid,
    input  logic [2*W-1:0] res_x,
    input  logic [2*W-1:0] res_y,
    output logic           busy,
    output logic           d_valid,
    output logic [1:0]     d_x,
    output logic [1:0]     d_y,
    output logic [IW-1:0]  iter,
    output logic           done,
    output logic [IW:0]    nz_count
);

    localparam logic [IW-1:0] LAST_ITER = IW'(N - 1);
    localparam logic [IW-1:0] ITER_ONE  = IW'(1);

    state_t         state;
    logic [2*W-1:0] res_x_q;
    logic [2*W-1:0] res_y_q;
    logic [1:0]     sel_x;
    logic [1:0]     sel_y;

    csd_window_select #(.W(W), .IW(IW)) u_sel_x (
        .residual (res_x_q),
        .iter     (iter),
        .digit    (sel_x)
    );

    csd_window_select #(.W(W), .IW(IW)) u_sel_y (
        .residual (res_y_q),
        .iter     (iter),
        .digit    (sel_y)
    );

    // Control FSM with registered strobes, digit outputs and residual storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            res_x_q <= '0;
            res_y_q <= '0;
            busy    <= 1'b0;
            d_valid <= 1'b0;
            done    <= 1'b0;
            d_x     <= CSD_ZERO;
            d_y     <= CSD_ZERO;
            iter    <= '0;
        end else begin
            d_valid <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        res_x_q <= x_in;
                        res_y_q <= y_in;
                        iter    <= '0;
                        busy    <= 1'b1;
                        state   <= SELECT;
                    end
                end
                SELECT: begin
                    d_x     <= sel_x;
                    d_y     <= sel_y;
                    d_valid <= 1'b1;
                    state   <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        res_x_q <= res_x;
                        res_y_q <= res_y;
                        if (iter == LAST_ITER) begin
                            state <= DONE;
                        end else begin
                            iter  <= iter + ITER_ONE;
                            state <= SELECT;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BKM_DSEL_NZ_COUNT_EN
    localparam logic [IW:0] NZ_ONE = (IW + 1)'(1);

    logic [IW:0] nz_q;

    // Counts non-zero digit pairs; the increment lands with the d_valid strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nz_q <= '0;
        end else if (state == IDLE && start) begin
            nz_q <= '0;
        end else if (state == SELECT && (sel_x != CSD_ZERO || sel_y != CSD_ZERO)
                     && nz_q != '1) begin
            nz_q <= nz_q + NZ_ONE;
        end
    end

    assign nz_count = nz_q;
`else
    assign nz_count = '0;
`endif

endmodule

// File: tb/tb_bkm_d_select_seq.sv
// Directed self-checking bench for bkm_d_select_seq at W=8, N=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bkm_d_select_seq;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;

    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] M = 2'b11;
    localparam logic [1:0] Z = 2'b00;

`ifdef BKM_DSEL_NZ_COUNT_EN
    localparam bit NZ_EN = 1'b1;
`else
    localparam bit NZ_EN = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*W-1:0] x_in;
    logic [2*W-1:0] y_in;
    logic           res_valid;
    logic [2*W-1:0] res_x;
    logic [2*W-1:0] res_y;
    logic           busy;
    logic           d_valid;
    logic [1:0]     d_x;
    logic [1:0]     d_y;
    logic [IW-1:0]  iter;
    logic           done;
    logic [IW:0]    nz_count;

    int errors = 0;
    int checks = 0;

    bkm_d_select_seq #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .res_valid (res_valid),
        .res_x     (res_x),
        .res_y     (res_y),
        .busy      (busy),
        .d_valid   (d_valid),
        .d_x       (d_x),
        .d_y       (d_y),
        .iter      (iter),
        .done      (done),
        .nz_count  (nz_count)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Residual with a single CSD digit k set to code
    function automatic logic [2*W-1:0] dig(input int k, input logic [1:0] code);
        logic [2*W-1:0] v;
        v = '0;
        v[2*k +: 2] = code;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        res_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Called at the negedge after a d_valid edge; returns at the negedge after
    // the residual is accepted (res_valid sampled 3 cycles after d_valid)
    task automatic feed_residual(input logic [2*W-1:0] rx, input logic [2*W-1:0] ry);
        tick();
        tick();
        res_x = rx;
        res_y = ry;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        res_x = '0;
        res_y = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        x_in = '0;
        y_in = '0;
        res_valid = 1'b0;
        res_x = '0;
        res_y = '0;
        @(negedge clk);
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset d_valid: got %b expected 0", d_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b expected 0", done); end
        checks++; if (d_x !== Z) begin errors++; $display("[TB] FAIL reset d_x: got %b expected 00", d_x); end
        checks++; if (d_y !== Z) begin errors++; $display("[TB] FAIL reset d_y: got %b expected 00", d_y); end
        checks++; if (iter !== 2'd0) begin errors++; $display("[TB] FAIL reset iter: got %0d expected 0", iter); end
        checks++; if (nz_count !== 3'd0) begin errors++; $display("[TB] FAIL reset nz_count: got %0d expected 0", nz_count); end
        rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle busy: got %b expected 0", busy); end
    endtask

    task automatic test_first_digit();
        do_reset();
        x_in = dig(7, P) | dig(6, P);
        y_in = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first busy: got %b expected 1", busy); end
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL first early d_valid: got %b expected 0", d_valid); end
        tick();
        checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL first d_valid: got %b expected 1", d_valid); end
        checks++; if (d_x !== P) begin errors++; $display("[TB] FAIL first d_x: got %b expected 01", d_x); end
        checks++; if (d_y !== Z) begin errors++; $display("[TB] FAIL first d_y: got %b expected 00", d_y); end
        checks++; if (iter !== 2'd0) begin errors++; $display("[TB] FAIL first iter: got %0d expected 0", iter); end
        tick();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL first strobe width: got %b expected 0", d_valid); end
        checks++; if (d_x !== P) begin errors++; $display("[TB] FAIL first d_x hold: got %b expected 01", d_x); end
    endtask

    task automatic test_neg_digit();
        do_reset();
        x_in = dig(6, M);
        y_in = dig(5, P);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL neg d_valid: got %b expected 1", d_valid); end
        checks++; if (d_x !== M) begin errors++; $display("[TB] FAIL neg d_x: got %b expected 11", d_x); end
        checks++; if (d_y !== Z) begin errors++; $display("[TB] FAIL neg d_y: got %b expected 00", d_y); end
    endtask

    task automatic test_full_op();
        logic [1:0]     exp_dx [4];
        logic [1:0]     exp_dy [4];
        logic [IW:0]    exp_nz [4];
        logic [2*W-1:0] nx [4];
        logic [2*W-1:0] ny [4];
        exp_dx[0] = P; exp_dx[1] = Z; exp_dx[2] = M; exp_dx[3] = Z;
        exp_dy[0] = Z; exp_dy[1] = Z; exp_dy[2] = P; exp_dy[3] = Z;
        exp_nz[0] = NZ_EN ? 3'd1 : 3'd0;
        exp_nz[1] = NZ_EN ? 3'd1 : 3'd0;
        exp_nz[2] = NZ_EN ? 3'd2 : 3'd0;
        exp_nz[3] = NZ_EN ? 3'd2 : 3'd0;
        nx[0] = '0;                    ny[0] = '0;
        nx[1] = dig(5, M);             ny[1] = dig(5, P);
        nx[2] = dig(3, P) | dig(2, M); ny[2] = '0;
        nx[3] = '0;                    ny[3] = '0;

        do_reset();
        x_in = dig(7, P) | dig(6, P);
        y_in = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL full d_valid it%0d: got %b expected 1", i, d_valid); end
            checks++; if (d_x !== exp_dx[i]) begin errors++; $display("[TB] FAIL full d_x it%0d: got %b expected %b", i, d_x, exp_dx[i]); end
            checks++; if (d_y !== exp_dy[i]) begin errors++; $display("[TB] FAIL full d_y it%0d: got %b expected %b", i, d_y, exp_dy[i]); end
            checks++; if (iter !== 2'(i)) begin errors++; $display("[TB] FAIL full iter it%0d: got %0d expected %0d", i, iter, i); end
            checks++; if (nz_count !== exp_nz[i]) begin errors++; $display("[TB] FAIL full nz_count it%0d: got %0d expected %0d", i, nz_count, exp_nz[i]); end
            if (i == 1) begin
                start = 1'b1;
                x_in = '1;
            end
            tick();
            checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL full wait d_valid it%0d: got %b expected 0", i, d_valid); end
            checks++; if (d_x !== exp_dx[i]) begin errors++; $display("[TB] FAIL full d_x hold it%0d: got %b expected %b", i, d_x, exp_dx[i]); end
            tick();
            start = 1'b0;
            x_in = '0;
            res_x = nx[i];
            res_y = ny[i];
            res_valid = 1'b1;
            tick();
            res_valid = 1'b0;
            if (i < 3) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL full busy it%0d: got %b expected 1", i, busy); end
                tick();
            end
        end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL full early done: got %b expected 0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL full busy before done: got %b expected 1", busy); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL full done: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL full busy at done: got %b expected 0", busy); end
        checks++; if (iter !== 2'd3) begin errors++; $display("[TB] FAIL full iter at done: got %0d expected 3", iter); end
        checks++; if (nz_count !== exp_nz[3]) begin errors++; $display("[TB] FAIL full nz_count at done: got %0d expected %0d", nz_count, exp_nz[3]); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL full done width: got %b expected 0", done); end
        checks++; if (nz_count !== exp_nz[3]) begin errors++; $display("[TB] FAIL full nz_count hold: got %0d expected %0d", nz_count, exp_nz[3]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        x_in = '0;
        y_in = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            feed_residual('0, '0);
            if (i < 3) tick();
        end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b first done: got %b expected 1", done); end
        x_in = '0;
        y_in = dig(7, M) | dig(6, M);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b busy: got %b expected 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b done cleared: got %b expected 0", done); end
        tick();
        checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b d_valid: got %b expected 1", d_valid); end
        checks++; if (d_y !== M) begin errors++; $display("[TB] FAIL b2b d_y: got %b expected 11", d_y); end
        checks++; if (iter !== 2'd0) begin errors++; $display("[TB] FAIL b2b iter: got %0d expected 0", iter); end
        feed_residual('0, '0);
        tick();
        feed_residual('0, '0);
        tick();
        feed_residual(dig(4, P) | dig(3, M) | dig(2, P), '0);
        tick();
        checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL win3 d_valid: got %b expected 1", d_valid); end
        checks++; if (iter !== 2'd3) begin errors++; $display("[TB] FAIL win3 iter: got %0d expected 3", iter); end
        checks++; if (d_x !== P) begin errors++; $display("[TB] FAIL win3 d_x: got %b expected 01", d_x); end
        feed_residual('0, '0);
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b second done: got %b expected 1", done); end
    endtask

    task automatic test_midop_reset();
        bit saw_done;
        do_reset();
        x_in = dig(7, P) | dig(6, P);
        y_in = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        feed_residual(dig(5, P) | dig(4, P), '0);
        tick();
        feed_residual(dig(5, P), '0);
        tick();
        checks++; if (iter !== 2'd2) begin errors++; $display("[TB] FAIL mid iter before reset: got %0d expected 2", iter); end
        checks++; if (d_x !== P) begin errors++; $display("[TB] FAIL mid d_x before reset: got %b expected 01", d_x); end
        tick();
        res_x = dig(4, P);
        res_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid busy: got %b expected 0", busy); end
        checks++; if (d_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid d_valid: got %b expected 0", d_valid); end
        checks++; if (d_x !== Z) begin errors++; $display("[TB] FAIL mid d_x: got %b expected 00", d_x); end
        checks++; if (d_y !== Z) begin errors++; $display("[TB] FAIL mid d_y: got %b expected 00", d_y); end
        checks++; if (iter !== 2'd0) begin errors++; $display("[TB] FAIL mid iter: got %0d expected 0", iter); end
        checks++; if (nz_count !== 3'd0) begin errors++; $display("[TB] FAIL mid nz_count: got %0d expected 0", nz_count); end
        tick();
        res_valid = 1'b0;
        res_x = '0;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("[TB] FAIL mid spurious done: got %b expected 0", saw_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid idle busy: got %b expected 0", busy); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++; if (d_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid restart d_valid: got %b expected 1", d_valid); end
        checks++; if (d_x !== P) begin errors++; $display("[TB] FAIL mid restart d_x: got %b expected 01", d_x); end
        checks++; if (iter !== 2'd0) begin errors++; $display("[TB] FAIL mid restart iter: got %0d expected 0", iter); end
    endtask

    // Scenario sequence followed by the single summary line
    initial begin
        test_reset();
        test_first_digit();
        test_neg_digit();
        test_full_op();
        test_back_to_back();
        test_midop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
